analog_cfg_spi: RTL and testbench
=================================

# analog_cfg_spi

SPI-mode-0 slave that configures the analog core of the chip and reads back its status. It feeds trim and control bits into the analog macro and snapshots the macro's digital status lines for readback. It sits directly upstream of the analog top and replaces that block's tied-off `uio` outputs: `uio_in` carries the SPI inputs and `uio_out`/`uio_oe` carry MISO.

## Interface
Parameters:
- `ID_VALUE`, default 8'hA5: constant returned by register 0x03.
- `TRIM_RESET`, default 8'h80: reset value of TRIM, the mid-scale trim code.

Ports:
- `clk` in 1: system clock. Must run at least 4× the SCK frequency.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `spi_sck` in 1: SPI clock, asynchronous to `clk`.
- `spi_cs_n` in 1: chip select, active low, asynchronous.
- `spi_mosi` in 1: serial data in, asynchronous.
- `spi_miso` out 1: serial data out.
- `spi_miso_oe` out 1: output enable for the MISO pad, high only while CS is asserted.
- `status_in` in 8: status lines from the analog core, asynchronous.
- `cfg_trim` out 8: TRIM register, drives the analog trim bits.
- `cfg_ctrl` out 8: CTRL register, drives the analog enables.
- `wr_strobe` out 1: pulses for one clock when a write commits.

## Operation
- **Input synchronization:** SCK, CS_n and MOSI each pass through a 2-FF synchronizer.
  - SCK additionally passes through an edge detector producing `sck_rise` and `sck_fall` pulses, each one `clk` wide.
  - MOSI is sampled on `sck_rise`, MSB first.
- **Frame format (16 bits):**
  - bit15: R/W (1 = write).
  - bits14:8: address (7 bits).
  - bits7:0: data.
- **Register map:**
  - 0x00 TRIM: RW, resets to `TRIM_RESET`.
  - 0x01 CTRL: RW, resets to 0x00.
  - 0x02 STATUS: RO, snapshot of synchronized `status_in`.
  - 0x03 ID: RO, returns `ID_VALUE`.
  - Any other address reads 0x00; writes to it are dropped.
- **State machine** (`bit_cnt` is a 4-bit counter):
  - IDLE → CMD when synchronized CS_n falls; `bit_cnt` is cleared.
  - CMD: shifts in 8 bits. On the 8th `sck_rise`, the address is decoded and the read data is loaded into the output shift register.
    - For STATUS, `status_in` is captured at this point.
    - Then → DATA.
  - DATA: shifts in 8 bits. On the 16th `sck_rise`:
    - If W and the address is writable, the register updates on that clock and `wr_strobe` pulses.
    - Then → DONE.
  - DONE: ignores further SCK edges until CS_n rises, then → IDLE.
  - From any state, CS_n rising → IDLE. Partial frames commit nothing.
- **MISO behaviour:**
  - Driven from the MSB of the output shift register; the register shifts on `sck_fall` in DATA state only.
  - In CMD state MISO = 0.
  - For writes, MISO echoes the old register value.
  - After DONE, MISO holds the last bit.
  - `spi_miso_oe` = inverse of synchronized CS_n.

## Timing
- **Reset values:**
  - `cfg_trim` = `TRIM_RESET`; `cfg_ctrl` = 0x00.
  - `spi_miso` = 0; `spi_miso_oe` = 0; `wr_strobe` = 0.
  - State = IDLE; shift registers = 0.
- **Latency:**
  - SCK pin edge → edge pulse: 3 `clk` edges.
  - Commit: `cfg_*` and `wr_strobe` update on the `clk` edge that consumes the 16th `sck_rise`, visible in the following cycle.
- **Reset mid-frame:** asynchronous clear of everything. The following frame starts only after a fresh CS_n falling edge; if CS_n is already low when reset releases, the state machine waits for CS_n to rise and fall again.
- **Simultaneous events:** if CS_n rises in the same cycle as the 16th `sck_rise`, the write still commits (CS deassert has lower priority).
- **Counter wrap:** `bit_cnt` saturates in DONE; bits beyond 16 never wrap back into CMD.
- **Sampling constraint:** `clk` ≥ 4× SCK. At slower ratios, behaviour is undefined and is not verified.

## Structure
- Package `analog_cfg_pkg`:
  - Register address localparams: `ADDR_TRIM`, `ADDR_CTRL`, `ADDR_STATUS`, `ADDR_ID`.
  - Reset-value constants.
  - State enum: `IDLE`, `CMD`, `DATA`, `DONE`.
- Sub-module `sync_edge`: 2-FF synchronizer plus optional rise/fall detector.
  - Instantiated for SCK (edges used), CS_n (level and rise used) and MOSI (level only).
  - `status_in` uses a bus variant of the 2-FF synchronizer without edge detection.

## Test plan
- Reset, no SPI activity → `cfg_trim`=0x80, `cfg_ctrl`=0x00, `spi_miso_oe`=0.
- Write frame 0x81 0x3C (write CTRL = 0x3C) → `cfg_ctrl`=0x3C, single `wr_strobe` pulse; read 0x01 then returns 0x3C on MISO.
- Read ID, frame 0x03 0x00 → MISO bits 7:0 = 0xA5.
- Drive `status_in`=0x5A before the 8th SCK of a read of 0x02, change it to 0xFF during the data phase → read returns 0x5A.
- Write 0x80 0x11 but raise CS_n after 12 SCK edges → `cfg_trim` stays 0x80, no `wr_strobe`. The next full write of 0x80 0x11 → `cfg_trim`=0x11.
- Write to 0x02 or 0x7F with data 0xFF, 20 SCK edges in the frame → no register changes, no strobe; the 4 extra edges are ignored.

Source files
------------

// File: rtl/analog_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : analog_cfg_pkg
//  Description : Shared register map, reset constants, FSM state type and
//                decode helpers for the analog configuration SPI slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package analog_cfg_pkg;

  // Register addresses (7-bit address field of the command byte)
  localparam logic [6:0] ADDR_TRIM   = 7'h00;
  localparam logic [6:0] ADDR_CTRL   = 7'h01;
  localparam logic [6:0] ADDR_STATUS = 7'h02;
  localparam logic [6:0] ADDR_ID     = 7'h03;

  // Reset / default values
  localparam logic [7:0] TRIM_RESET_DFLT = 8'h80;
  localparam logic [7:0] CTRL_RESET_VAL  = 8'h00;
  localparam logic [7:0] ID_DFLT         = 8'hA5;

  // Bit counter landmarks within the 16-bit frame
  localparam logic [3:0] CMD_LAST_BIT   = 4'd7;
  localparam logic [3:0] DATA_FIRST_BIT = 4'd8;
  localparam logic [3:0] DATA_LAST_BIT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Only TRIM and CTRL accept writes; everything else silently drops them
  function automatic logic addr_writable(input logic [6:0] addr);
    return (addr == ADDR_TRIM) || (addr == ADDR_CTRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/analog_cfg_spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : 2-FF synchronizer for a WIDTH-bit bus with an optional
//                rise/fall pulse detector on bit 0 (pulses one clk wide).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int               WIDTH   = 1,
  parameter bit               EDGE_EN = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage metastability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Delayed copy of the synchronized level for edge detection
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= RST_VAL[0];
        end else begin
          prev_q <= sync_q[0];
        end
      end

      assign rise_o =  sync_q[0] & ~prev_q;
      assign fall_o = ~sync_q[0] &  prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/analog_cfg_spi.sv
`default_nettype none
// ============================================================================
//  Module      : analog_cfg_spi
//  Description : SPI mode-0 slave holding the analog TRIM/CTRL registers and
//                providing STATUS snapshot and ID readback. 16-bit frames:
//                {R/W, addr[6:0], data[7:0]}, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module analog_cfg_spi
  import analog_cfg_pkg::*;
#(
  parameter logic [7:0] ID_VALUE   = ID_DFLT,
  parameter logic [7:0] TRIM_RESET = TRIM_RESET_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status_in,
  output logic [7:0] cfg_trim,
  output logic [7:0] cfg_ctrl,
  output logic       wr_strobe
);

  // Synchronized inputs
  logic       sck_rise, sck_fall;
  logic       sck_level_unused;
  logic       cs_level, cs_rise, cs_fall;
  logic       mosi_s;
  logic       mosi_rise_unused, mosi_fall_unused;
  logic [7:0] status_s;
  logic       status_rise_unused, status_fall_unused;

  sync_edge #(.WIDTH(1), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sync_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_sck),
    .q_o    (sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // CS_n idles deasserted so reset never looks like a chip select
  sync_edge #(.WIDTH(1), .EDGE_EN(1'b1), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge #(.WIDTH(1), .EDGE_EN(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  sync_edge #(.WIDTH(8), .EDGE_EN(1'b0), .RST_VAL(8'h00)) u_sync_status (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (status_in),
    .q_o    (status_s),
    .rise_o (status_rise_unused),
    .fall_o (status_fall_unused)
  );

  // Frame state
  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_in_q;
  logic [7:0] shift_out_q;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] trim_q;
  logic [7:0] ctrl_q;
  logic       wr_strobe_q;
  logic [1:0] flush_q;   // marks when the CS synchronizer holds real pin samples
  logic       armed_q;   // CS_n seen high since reset; a fall may start a frame

  // Combinational decode of the byte completing on the current sck_rise
  logic [6:0] addr_d;
  logic [7:0] data_d;
  logic [7:0] rd_data_d;
  logic       last_rise;

  assign addr_d    = {shift_in_q[5:0], mosi_s};
  assign data_d    = {shift_in_q, mosi_s};
  assign last_rise = (state_q == DATA) && sck_rise && (bit_cnt_q == DATA_LAST_BIT);

  // Read data mux, evaluated on the 8th rise; STATUS is captured here
  always_comb begin
    rd_data_d = 8'h00;
    case (addr_d)
      ADDR_TRIM:   rd_data_d = trim_q;
      ADDR_CTRL:   rd_data_d = ctrl_q;
      ADDR_STATUS: rd_data_d = status_s;
      ADDR_ID:     rd_data_d = ID_VALUE;
      default:     rd_data_d = 8'h00;
    endcase
  end

  // Frame FSM, shift registers and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 8'd0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      trim_q      <= TRIM_RESET;
      ctrl_q      <= CTRL_RESET_VAL;
      wr_strobe_q <= 1'b0;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      flush_q     <= {flush_q[0], 1'b1};
      if (flush_q[1] && cs_level) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (armed_q && cs_fall) begin
            state_q    <= CMD;
            bit_cnt_q  <= 4'd0;
            shift_in_q <= 7'd0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            shift_in_q <= data_d[6:0];
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == CMD_LAST_BIT) begin
              addr_q      <= addr_d;
              rw_q        <= shift_in_q[6];
              shift_out_q <= rd_data_d;
              state_q     <= DATA;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            shift_in_q <= data_d[6:0];
            if (bit_cnt_q == DATA_LAST_BIT) begin
              // counter parks at 15 so trailing edges can never re-enter CMD
              if (rw_q && addr_writable(addr_q)) begin
                if (addr_q == ADDR_TRIM) trim_q <= data_d;
                else                     ctrl_q <= data_d;
                wr_strobe_q <= 1'b1;
              end
              state_q <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (sck_fall && (bit_cnt_q != DATA_FIRST_BIT)) begin
            // the fall right after the load only presents bit 7; later falls advance
            shift_out_q <= {shift_out_q[6:0], 1'b0};
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase

      // CS deassert aborts the frame, except on the committing edge itself
      if (cs_rise && !last_rise) begin
        state_q <= IDLE;
      end
    end
  end

  assign spi_miso    = (state_q == CMD) ? 1'b0 : shift_out_q[7];
  assign spi_miso_oe = ~cs_level;
  assign cfg_trim    = trim_q;
  assign cfg_ctrl    = ctrl_q;
  assign wr_strobe   = wr_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_analog_cfg_spi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_analog_cfg_spi
//  Description : Self-checking bench for analog_cfg_spi: directed frames for
//                the key scenarios plus randomized frames against a register
//                model of the SPI map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_analog_cfg_spi;

  localparam int HALF = 4;  // clk cycles per SCK half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] status_in = 8'h00;
  logic       spi_miso, spi_miso_oe, wr_strobe;
  logic [7:0] cfg_trim, cfg_ctrl;

  analog_cfg_spi dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .status_in   (status_in),
    .cfg_trim    (cfg_trim),
    .cfg_ctrl    (cfg_ctrl),
    .wr_strobe   (wr_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int strobe_hi = 0;   // total clk cycles with wr_strobe high

  // Register model
  logic [7:0] m_trim = 8'h80;
  logic [7:0] m_ctrl = 8'h00;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_hi++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] addr);
    case (addr)
      7'h00:   return m_trim;
      7'h01:   return m_ctrl;
      7'h02:   return status_in;
      7'h03:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_release();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  // Clock out nedges SCK pulses; MISO is sampled at each rising pin edge
  task automatic shift(input logic [15:0] frame, input int nedges, input logic [8:0] st_chg,
                       output logic [7:0] miso_bits, output logic oe_seen);
    miso_bits = 8'h00;
    oe_seen   = 1'b0;
    for (int i = 0; i < nedges; i++) begin
      spi_mosi = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
      if (i == 10 && st_chg[8]) status_in = st_chg[7:0];
      tick(HALF);
      if (i >= 8 && i < 16) miso_bits[15-i] = spi_miso;
      if (i == 0) oe_seen = spi_miso_oe;
      spi_sck = 1'b1;
      tick(HALF);
      spi_sck = 1'b0;
    end
  endtask

  // One full checked transaction against the model
  task automatic xfer(input string tag, input logic rw, input logic [6:0] addr,
                      input logic [7:0] data, input int nedges, input logic [8:0] st_chg);
    logic [7:0] mb;
    logic       oe;
    logic [7:0] expm;
    int         s0;
    bit         wr;
    expm = model_read(addr);
    s0   = strobe_hi;
    cs_assert();
    shift({rw, addr, data}, nedges, st_chg, mb, oe);
    cs_release();
    wr = (nedges >= 16) && rw && (addr == 7'h00 || addr == 7'h01);
    if (wr) begin
      if (addr == 7'h00) m_trim = data;
      else               m_ctrl = data;
    end
    chk({tag, "_oe_active"}, 16'(oe), 16'h1);
    if (nedges >= 16) chk({tag, "_miso"}, 16'(mb), 16'(expm));
    chk({tag, "_strobe"}, 16'(strobe_hi - s0), wr ? 16'h1 : 16'h0);
    chk({tag, "_trim"}, 16'(cfg_trim), 16'(m_trim));
    chk({tag, "_ctrl"}, 16'(cfg_ctrl), 16'(m_ctrl));
    chk({tag, "_oe_idle"}, 16'(spi_miso_oe), 16'h0);
  endtask

  initial begin
    logic [7:0] mb;
    logic       oe;
    int         s0;
    logic [6:0] ra;
    int         ne;

    // Reset state
    tick(3);
    chk("rst_trim", 16'(cfg_trim), 16'h80);
    chk("rst_ctrl", 16'(cfg_ctrl), 16'h00);
    chk("rst_oe", 16'(spi_miso_oe), 16'h0);
    chk("rst_miso", 16'(spi_miso), 16'h0);
    chk("rst_strobe", 16'(wr_strobe), 16'h0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_trim", 16'(cfg_trim), 16'h80);
    chk("idle_oe", 16'(spi_miso_oe), 16'h0);

    // Directed scenarios
    xfer("wr_ctrl", 1'b1, 7'h01, 8'h3C, 16, 9'h000);
    xfer("rd_ctrl", 1'b0, 7'h01, 8'h00, 16, 9'h000);
    xfer("rd_id", 1'b0, 7'h03, 8'h00, 16, 9'h000);
    status_in = 8'h5A;
    xfer("rd_status", 1'b0, 7'h02, 8'h00, 16, 9'h1FF);
    xfer("wr_trim_part", 1'b1, 7'h00, 8'h11, 12, 9'h000);
    xfer("wr_trim_full", 1'b1, 7'h00, 8'h11, 16, 9'h000);
    xfer("wr_status_ro", 1'b1, 7'h02, 8'hFF, 20, 9'h000);
    xfer("wr_unmapped", 1'b1, 7'h7F, 8'hFF, 20, 9'h000);
    xfer("wr_echo_old", 1'b1, 7'h00, 8'h42, 16, 9'h000);

    // CS_n rising together with the 16th SCK rise still commits
    s0 = strobe_hi;
    cs_assert();
    shift({1'b1, 7'h00, 8'hC3}, 15, 9'h000, mb, oe);
    spi_mosi = 1'b1;
    tick(HALF);
    spi_sck  = 1'b1;
    spi_cs_n = 1'b1;
    tick(HALF);
    spi_sck = 1'b0;
    tick(8);
    m_trim = 8'hC3;
    chk("simul_trim", 16'(cfg_trim), 16'hC3);
    chk("simul_strobe", 16'(strobe_hi - s0), 16'h1);

    // Reset mid-frame with CS_n held low: no frame until a fresh CS_n fall
    cs_assert();
    shift({1'b1, 7'h01, 8'h77}, 10, 9'h000, mb, oe);
    rst_n = 1'b0;
    tick(2);
    m_trim = 8'h80;
    m_ctrl = 8'h00;
    chk("midrst_trim", 16'(cfg_trim), 16'h80);
    chk("midrst_ctrl", 16'(cfg_ctrl), 16'h00);
    chk("midrst_miso", 16'(spi_miso), 16'h0);
    rst_n = 1'b1;
    tick(4);
    s0 = strobe_hi;
    shift({1'b1, 7'h01, 8'h77}, 16, 9'h000, mb, oe);
    tick(6);
    chk("postrst_ctrl", 16'(cfg_ctrl), 16'h00);
    chk("postrst_strobe", 16'(strobe_hi - s0), 16'h0);
    cs_release();
    xfer("postrst_wr", 1'b1, 7'h01, 8'h77, 16, 9'h000);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = 7'h00;
        1:       ra = 7'h01;
        2:       ra = 7'h02;
        3:       ra = 7'h03;
        default: ra = 7'($urandom_range(4, 127));
      endcase
      case ($urandom_range(0, 5))
        0:       ne = $urandom_range(3, 15);
        1:       ne = $urandom_range(17, 20);
        default: ne = 16;
      endcase
      status_in = 8'($urandom);
      tick(3);
      xfer("rand", 1'($urandom_range(0, 1)), ra, 8'($urandom), ne, 9'h000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
